// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine on a req/ack data port.
// Optional feature macro MISALIGN_TRAP_EN traps misaligned H/W accesses.
module mem_access_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_forward_rs2_data,
    output logic        mem_stall,
    output logic [31:0] MEM_load_data,
    output logic        mem_timeout,
`ifdef MISALIGN_TRAP_EN
    output logic        mem_misalign,
`endif
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;
    logic [1:0]       off;
    logic             access;
    logic             is_byte;
    logic             is_half;
    logic             misal;
    logic             expire;
    logic [3:0]       wstrb_w;
    logic [31:0]      wdata_w;
    logic [31:0]      ext;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
`ifdef MISALIGN_TRAP_EN
    logic             misal_q;
`endif

    assign off     = MEM_alu_out[1:0];
    assign access  = MemRead | MemWrite;
    assign is_byte = (MEM_funct3[1:0] == 2'b00);
    assign is_half = (MEM_funct3[1:0] == 2'b01);
    assign expire  = (cnt == LAST);
    assign lane_b  = dm_rdata[{off, 3'b000} +: 8];
    assign lane_h  = dm_rdata[{off[1], 4'b0000} +: 16];

`ifdef MISALIGN_TRAP_EN
    assign misal = (is_half & off[0]) |
                   (~is_byte & ~is_half & (off != 2'b00));
`else
    assign misal = 1'b0;
`endif

    // Byte strobes and lane-replicated store data.
    always_comb begin
        wstrb_w = 4'b1111;
        wdata_w = MEM_forward_rs2_data;
        unique case (1'b1)
            is_byte: begin
                wstrb_w = 4'b0001 << off;
                wdata_w = {4{MEM_forward_rs2_data[7:0]}};
            end
            is_half: begin
                wstrb_w = 4'b0011 << {off[1], 1'b0};
                wdata_w = {2{MEM_forward_rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection with sign/zero extension.
    always_comb begin
        ext = dm_rdata;
        unique case (1'b1)
            is_byte: ext = MEM_funct3[2] ? {24'b0, lane_b}
                                         : {{24{lane_b[7]}}, lane_b};
            is_half: ext = MEM_funct3[2] ? {16'b0, lane_h}
                                         : {{16{lane_h[15]}}, lane_h};
            default: ;
        endcase
    end

    // Next state, request and stall; all forced low while in reset.
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        dm_req    = 1'b0;
        unique case (state)
            IDLE: begin
                if (access) begin
                    if (misal) begin
                        state_nxt = DONE;
                    end else begin
                        dm_req    = 1'b1;
                        mem_stall = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                dm_req    = 1'b1;
                mem_stall = 1'b1;
                if (dm_ack || expire) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            dm_req    = 1'b0;
            mem_stall = 1'b0;
        end
    end

    assign dm_we       = dm_req & MemWrite;
    assign dm_wstrb    = dm_we ? wstrb_w : 4'b0000;
    assign dm_addr     = {MEM_alu_out[31:2], 2'b00};
    assign dm_wdata    = wdata_w;
    assign mem_timeout = timeout_q;
`ifdef MISALIGN_TRAP_EN
    assign mem_misalign = misal_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Wait counter, load result and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            MEM_load_data <= '0;
            timeout_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misal_q       <= 1'b0;
`endif
        end else begin
            timeout_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misal_q   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access && misal) begin
                        MEM_load_data <= '0;
`ifdef MISALIGN_TRAP_EN
                        misal_q       <= 1'b1;
`endif
                    end
                end
                BUSY: begin
                    if (dm_ack) begin
                        MEM_load_data <= MemWrite ? 32'h0 : ext;
                    end else if (expire) begin
                        MEM_load_data <= '0;
                        timeout_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule
